// File: rtl/cal_hu_mul_sched_pkg.sv
// Shared constants and helpers for the CAL_Hu shared-multiplier scheduler.
// The multiplier is 8x14 unsigned with a fixed three-stage pipeline.
package cal_hu_mul_sched_pkg;

  localparam int A_W     = 8;
  localparam int B_W     = 14;
  localparam int P_W     = 22;
  localparam int MUL_LAT = 3;

  // Candidate index k steps past the last grant, wrapping at n.
  function automatic int rr_next(input int last, input int k, input int n);
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/cal_hu_mul_sched_rr.sv
// Combinational round-robin arbiter: searches from last_grant+1 and wraps,
// producing a one-hot grant plus its index when enabled.
module cal_hu_mul_sched_rr
  import cal_hu_mul_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last_grant,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_idx,
  output logic             o_grant_valid
);

  logic [ID_W-1:0] w_cand;

  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = ID_W'(rr_next(int'(i_last_grant), k, N_REQ));
      if (i_en && !o_grant_valid && i_req[w_cand]) begin
        o_grant_valid   = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_grant_idx     = w_cand;
      end
    end
  end

endmodule

// File: rtl/cal_hu_mul_sched.sv
// Round-robin scheduler sharing one pipelined 8x14 multiplier among N_REQ
// requesters; results return in issue order and the pipe freezes on back-pressure.
module cal_hu_mul_sched
  import cal_hu_mul_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TAG_W = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*A_W-1:0]   req_a,
  input  logic [N_REQ*B_W-1:0]   req_b,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [P_W-1:0]         res_data,
  output logic [ID_W-1:0]        res_id,
  output logic [TAG_W-1:0]       res_tag,
  output logic [2:0]             inflight
);

  typedef struct packed {
    logic             valid;
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
  } sb_t;

  sb_t             r_sb [MUL_LAT];
  logic [ID_W-1:0] r_last_grant;
  logic [A_W-1:0]  r_a0;
  logic [B_W-1:0]  r_b0;
  logic [P_W-1:0]  r_p1;
  logic [P_W-1:0]  r_p2;

  logic             w_ce;
  logic             w_en;
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_gnt_valid;
  logic [A_W-1:0]   w_a;
  logic [B_W-1:0]   w_b;
  logic [TAG_W-1:0] w_tag;
  logic [2:0]       w_cnt;

  // Only a held, unaccepted result stalls the pipe; grants are suppressed during reset.
  assign w_ce = !(r_sb[MUL_LAT-1].valid && !res_ready);
  assign w_en = w_ce && !reset;

  cal_hu_mul_sched_rr #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .i_req         (req_valid),
    .i_last_grant  (r_last_grant),
    .i_en          (w_en),
    .o_grant       (w_gnt),
    .o_grant_idx   (w_gnt_idx),
    .o_grant_valid (w_gnt_valid)
  );

  assign req_ready = w_gnt;
  assign w_a       = req_a[int'(w_gnt_idx)*A_W +: A_W];
  assign w_b       = req_b[int'(w_gnt_idx)*B_W +: B_W];
  assign w_tag     = req_tag[int'(w_gnt_idx)*TAG_W +: TAG_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= ID_W'(N_REQ - 1);
    end else if (w_gnt_valid) begin
      r_last_grant <= w_gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MUL_LAT; k++) r_sb[k] <= '0;
    end else if (w_ce) begin
      r_sb[0] <= '{valid: w_gnt_valid, id: w_gnt_idx, tag: w_tag};
      for (int k = 1; k < MUL_LAT; k++) r_sb[k] <= r_sb[k-1];
    end
  end

  // Datapath registers carry no reset; the sideband valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_ce) begin
      r_a0 <= w_a;
      r_b0 <= w_b;
      r_p1 <= P_W'(r_a0) * P_W'(r_b0);
      r_p2 <= r_p1;
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < MUL_LAT; k++) w_cnt = w_cnt + 3'(r_sb[k].valid);
  end

  assign inflight  = w_cnt;
  assign res_valid = r_sb[MUL_LAT-1].valid;
  assign res_data  = r_p2;
  assign res_id    = r_sb[MUL_LAT-1].id;
  assign res_tag   = r_sb[MUL_LAT-1].tag;

endmodule

// File: tb/tb_cal_hu_mul_sched.sv
// Directed bench for cal_hu_mul_sched: a negedge monitor keeps an issue-order
// scoreboard of products while the main sequence checks grants, stalls and reset.
module tb_cal_hu_mul_sched;

  localparam int N = 4;
  localparam int TW = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [21:0]   data;
    logic [IW-1:0] id;
    logic [TW-1:0] tag;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*8-1:0]  req_a = '0;
  logic [N*14-1:0] req_b = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [21:0]     res_data;
  logic [IW-1:0]   res_id;
  logic [TW-1:0]   res_tag;
  logic [2:0]      inflight;

  int   nCompared = 0;
  int   nMismatched = 0;
  exp_t sbQ[$];

  cal_hu_mul_sched #(.N_REQ(N), .TAG_W(TW), .ID_W(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_tag   (res_tag),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input int a, input int b, input int tag);
    req_a[i*8 +: 8]     = 8'(a);
    req_b[i*14 +: 14]   = 14'(b);
    req_tag[i*TW +: TW] = TW'(tag);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Holds valid for every pending requester until each one has been granted.
  task automatic runRequests(input logic [N-1:0] mask);
    logic [N-1:0] pending;
    int cnt;
    pending = mask;
    cnt = 0;
    while (pending != '0 && cnt < 20) begin
      req_valid = pending;
      @(negedge clk);
      pending = pending & ~req_ready;
      nextCycle();
      cnt++;
    end
    req_valid = '0;
    checkOutput("grant_timeout", 32'(pending), 32'd0);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) nextCycle();
  endtask

  // Scoreboard: push on accepted issue, pop and compare on accepted result.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sbQ.delete();
    end else begin
      if (res_valid && res_ready) begin
        checkOutput("result_expected", 32'(sbQ.size() != 0), 32'd1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          checkOutput("res_data", 32'(res_data), 32'(e.data));
          checkOutput("res_id", 32'(res_id), 32'(e.id));
          checkOutput("res_tag", 32'(res_tag), 32'(e.tag));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.data = 22'(int'(req_a[i*8 +: 8]) * int'(req_b[i*14 +: 14]));
          e.id   = IW'(i);
          e.tag  = req_tag[i*TW +: TW];
          sbQ.push_back(e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset: outputs idle and no grant even with all requesters valid.
    req_valid = '1;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_inflight", 32'(inflight), 32'd0);
    nextCycle();
    reset = 1'b0;
    req_valid = '0;

    // Single request from requester 2.
    applyStimulus(2, 200, 10000, 5);
    req_valid = 4'b0100;
    @(negedge clk);
    checkOutput("single_ready", 32'(req_ready), 32'b0100);
    nextCycle();
    req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput("single_inflight", 32'(inflight), 32'd1);
      checkOutput("single_res_valid", 32'(res_valid), (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) checkOutput("single_data", 32'(res_data), 32'd2000000);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("single_inflight_end", 32'(inflight), 32'd0);
    nextCycle();

    // Fairness after reset: all four valid for eight cycles.
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    for (int i = 0; i < N; i++) applyStimulus(i, i * 10 + 1, i * 100 + 3, i + 8);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
      nextCycle();
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("fair_b2b_valid", 32'(res_valid), (k < 3) ? 32'd1 : 32'd0);
      nextCycle();
    end

    // Operand extremes.
    applyStimulus(0, 255, 16383, 1);
    applyStimulus(1, 0, 1234, 2);
    applyStimulus(3, 77, 0, 3);
    runRequests(4'b1011);
    drain(4);

    // Back-pressure: three issues, stall five cycles at the first result.
    applyStimulus(0, 13, 999, 4);
    applyStimulus(1, 250, 16000, 6);
    applyStimulus(2, 99, 12345, 7);
    applyStimulus(3, 42, 4242, 9);
    runRequests(4'b0111);
    res_ready = 1'b0;
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_res_valid", 32'(res_valid), 32'd1);
      checkOutput("stall_data_hold", 32'(res_data), 32'(sbQ[0].data));
      checkOutput("stall_tag_hold", 32'(res_tag), 32'(sbQ[0].tag));
      checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
      checkOutput("stall_inflight", 32'(inflight), 32'd3);
      nextCycle();
    end
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_issue", 32'(req_ready), 32'b1000);
    checkOutput("release_res_valid", 32'(res_valid), 32'd1);
    nextCycle();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("release_stream", 32'(res_valid), (k < 3) ? 32'd1 : 32'd0);
      nextCycle();
    end

    // Reset with two operations in flight.
    runRequests(4'b0110);
    reset = 1'b1;
    req_valid = '1;
    @(negedge clk);
    checkOutput("midrst_inflight", 32'(inflight), 32'd2);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
    nextCycle();
    reset = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("midrst_flushed", 32'(res_valid), 32'd0);
      nextCycle();
    end
    applyStimulus(0, 11, 22, 12);
    applyStimulus(1, 33, 44, 13);
    req_valid = 4'b0011;
    @(negedge clk);
    checkOutput("midrst_ptr", 32'(req_ready), 32'b0001);
    nextCycle();
    req_valid = '0;
    drain(4);

    // Sparse traffic from requester 1 with a bubble between issues.
    applyStimulus(1, 17, 300, 14);
    req_valid = 4'b0010;
    @(negedge clk);
    checkOutput("sparse_grant0", 32'(req_ready), 32'b0010);
    nextCycle();
    req_valid = '0;
    nextCycle();
    applyStimulus(1, 201, 8191, 15);
    req_valid = 4'b0010;
    @(negedge clk);
    checkOutput("sparse_grant2", 32'(req_ready), 32'b0010);
    nextCycle();
    req_valid = '0;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      checkOutput("sparse_res_valid", 32'(res_valid), (k == 4) ? 32'd0 : 32'd1);
      nextCycle();
    end
    applyStimulus(0, 5, 6, 0);
    applyStimulus(2, 7, 8, 1);
    req_valid = 4'b0101;
    @(negedge clk);
    checkOutput("sparse_ptr", 32'(req_ready), 32'b0100);
    nextCycle();
    req_valid = '0;
    drain(5);

    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
